multi_blink: RTL and testbench
==============================

Name: multi_blink

Overview:
- Parametrised multi-channel LED pattern generator. Successor to the single fixed-rate toggle blinker.
- A shared prescaler produces a slow tick. Each channel independently runs OFF, ON, BLINK (programmable period and duty) or BURST (blink-code) mode.
- Channels are configured at runtime through a valid/ready port and drive board LEDs or GPIO pins directly.

Parameters:
- CLK_HZ, 16000000, input clock frequency.
- TICK_HZ, 1000, prescaler tick rate. DIV = CLK_HZ/TICK_HZ; DIV must be >= 2 (elaboration error otherwise).
- NUM_CH, 2, number of output channels (1..16).
- PER_W, 16, width of period/duty fields, in ticks.
- CNT_W, 4, width of the burst-count field.

Ports:
- CLK  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready at a CLK edge.
- cfg_chan  in  4  target channel.
- cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 BURST.
- cfg_period  in  PER_W  period in ticks; 0 is treated as 1.
- cfg_duty  in  PER_W  on-ticks per period.
- cfg_burst  in  CNT_W  pulses per burst; 0 is treated as 1.
- cfg_err  out  1  one-cycle pulse when an accepted cfg_chan >= NUM_CH.
- led  out  NUM_CH  channel outputs, registered.
- period_start  out  NUM_CH  one-cycle pulse when a channel's phase wraps to 0.
- pending  out  NUM_CH  a channel holds an uncommitted config.

Behaviour:
- Reset (async assert, sync release):
  - Prescaler = 0; all channels OFF with phase/burst counters = 0 and no pending config.
  - led = 0, period_start = 0, pending = 0, cfg_err = 0.
- Prescaler:
  - Counts 0..DIV-1.
  - tick = 1 for exactly one CLK cycle when the count is DIV-1, so there is one tick every DIV cycles.
- cfg_ready:
  - cfg_ready = !pending[cfg_chan] for in-range channels; 1 for out-of-range channels.
  - This is combinational from cfg_chan only; it never depends on cfg_valid.
- Accept, in-range channel:
  - Fields are stored in that channel's shadow register and pending is set the next cycle.
- Accept, out-of-range channel:
  - Data is dropped and cfg_err pulses the next cycle.
- Commit:
  - If the current mode is OFF or ON, the shadow is committed on the cycle after accept: phase = 0, burst count = 0, pending cleared.
  - If the current mode is BLINK or BURST, the shadow is committed on the next tick where phase wraps, so the current period always completes.
- Phase (BLINK/BURST only):
  - Increments on tick.
  - On a tick with phase == period-1: phase becomes 0 and period_start pulses in the same cycle the phase register becomes 0.
- led, registered and updated the cycle after the state change:
  - OFF: 0.
  - ON: 1.
  - BLINK: phase < duty. duty = 0 gives constant 0; duty >= period gives constant 1.
  - BURST:
    - The burst counter runs 0..2*burst-1 and increments at each period wrap.
    - led = (phase < duty) while counter < burst, else 0.
    - Result: burst pulses followed by burst silent periods.
- Simultaneous events on one channel:
  - A commit and a tick-wrap in the same cycle: the commit wins. Phase and burst counter = 0, and period_start still pulses.
  - An accept to a channel in the cycle its pending clears is impossible, because cfg_ready was 0 in that cycle.
- ON/OFF → BLINK: the first period starts at the commit cycle with phase 0, so led = 1 one cycle later if duty > 0.
- Reset mid-period: all state clears immediately and led drops to 0 asynchronously.
- Arithmetic: all comparisons are unsigned, at PER_W or CNT_W+1 bits. No overflow is possible, since the counters are bounded by the period and 2*burst.

Decomposition:
- Package multi_blink_pkg:
  - Mode encoding constants MODE_OFF/ON/BLINK/BURST.
  - Function computing DIV and its width ($clog2).
  - Channel config struct {mode, period, duty, burst}.
- Sub-module blink_channel:
  - One instance per channel, generated NUM_CH times.
  - Contains the shadow register, pending flag, phase counter, burst counter and led/period_start registers.
  - Takes tick, a write strobe and config fields as inputs.
- The top level holds the prescaler, address decode, cfg_ready mux and cfg_err.

Test Plan (CLK_HZ=16, TICK_HZ=4, so DIV=4; NUM_CH=2):
- Reset release → led=00, pending=00, cfg_ready=1. Ticks appear on cycles 3, 7, 11, …
- ch0 BLINK period=4 duty=1 from OFF → pending[0] pulses for one cycle. led[0] is high for 4 cycles, then low for 12, repeating every 16 cycles. period_start[0] pulses every 16 cycles.
- While ch0 is in BLINK, send ch0 ON → pending[0]=1 and cfg_ready=0 for cfg_chan=0 until the next wrap. Then led[0]=1 constantly. A second request to ch0 stalls, while ch1 is accepted immediately.
- ch1 BURST period=2 duty=1 burst=3 → over 12 ticks, led[1] shows 3 pulses of 1 tick at a 2-tick spacing, then 6 ticks low, then repeats.
- Edge cases:
  - duty=0 → led stays 0.
  - duty=9 with period=4 → led stays 1.
  - period=0 behaves exactly as period=1.
  - cfg_chan=5 → cfg_err pulses once and no channel changes.
- Assert reset_n mid-BURST → led=00 in the same cycle. After release all channels are OFF and the prescaler restarts from 0.

Source files
------------

// File: rtl/multi_blink_pkg.sv
// multi_blink_pkg: shared definitions for the multi-channel LED pattern generator.
//   mode_e      - channel mode encoding (OFF / ON / BLINK / BURST)
//   calc_div    - prescaler division ratio from clock and tick rates
//   calc_div_w  - register width needed to count 0..div-1
// The per-channel config struct depends on PER_W/CNT_W, so it is declared
// inside blink_channel where those widths are known.
package multi_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int calc_div_w(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/multi_blink_channel.sv
// blink_channel: one LED pattern channel.
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   tick_i                 - one-cycle prescaler tick
//   wr_i                   - accepted config write for this channel
//   mode_i/period_i/duty_i/burst_i - config fields captured on wr_i
//   led_o                  - registered LED output
//   period_start_o         - one-cycle pulse in the cycle phase becomes 0 after a wrap
//   pending_o              - shadow config not yet committed
module blink_channel
  import multi_blink_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             wr_i,
  input  mode_e            mode_i,
  input  logic [PER_W-1:0] period_i,
  input  logic [PER_W-1:0] duty_i,
  input  logic [CNT_W-1:0] burst_i,
  output logic             led_o,
  output logic             period_start_o,
  output logic             pending_o
);

  localparam int BW = CNT_W + 1;

  typedef struct packed {
    mode_e            mode;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] duty;
    logic [CNT_W-1:0] burst;
  } ch_cfg_t;

  // Period and burst are stored already normalised (0 -> 1) so the
  // counters never need a zero special case.
  localparam ch_cfg_t CFG_RST = '{
    mode:   MODE_OFF,
    period: PER_W'(1),
    duty:   {PER_W{1'b0}},
    burst:  CNT_W'(1)
  };

  ch_cfg_t          cur_q, cur_d;
  ch_cfg_t          shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [PER_W-1:0] phase_q, phase_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             led_q, led_d;
  logic             pstart_q, pstart_d;

  logic active_s;
  logic wrap_s;
  logic commit_s;
  logic burst_last_s;
  logic on_phase_s;

  // Event decode: phase wrap, commit point and burst counter terminal value.
  always_comb begin
    active_s     = (cur_q.mode == MODE_BLINK) || (cur_q.mode == MODE_BURST);
    wrap_s       = tick_i && active_s && (phase_q == (cur_q.period - PER_W'(1)));
    // OFF/ON have no period to finish, so a pending config commits at once.
    commit_s     = pending_q && (active_s ? wrap_s : 1'b1);
    burst_last_s = (bcnt_q == ({cur_q.burst, 1'b0} - BW'(1)));
    on_phase_s   = (phase_q < cur_q.duty);
  end

  // Next-state for config, shadow, pending flag and counters.
  always_comb begin
    cur_d     = cur_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    phase_d   = phase_q;
    bcnt_d    = bcnt_q;
    // Commit outranks a simultaneous wrap: both restart the period at 0.
    if (commit_s) begin
      cur_d     = shadow_q;
      pending_d = 1'b0;
      phase_d   = {PER_W{1'b0}};
      bcnt_d    = {BW{1'b0}};
    end else if (wrap_s) begin
      phase_d = {PER_W{1'b0}};
      bcnt_d  = burst_last_s ? {BW{1'b0}} : (bcnt_q + BW'(1));
    end else if (tick_i && active_s) begin
      phase_d = phase_q + PER_W'(1);
    end else begin
      phase_d = phase_q;
    end
    // wr_i only arrives while pending is clear, so it never races the commit.
    if (wr_i) begin
      shadow_d.mode   = mode_i;
      shadow_d.period = (period_i == {PER_W{1'b0}}) ? PER_W'(1) : period_i;
      shadow_d.duty   = duty_i;
      shadow_d.burst  = (burst_i == {CNT_W{1'b0}}) ? CNT_W'(1) : burst_i;
      pending_d       = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // LED value is derived from the current registered state, one cycle behind it.
  always_comb begin
    led_d    = 1'b0;
    pstart_d = wrap_s;
    case (cur_q.mode)
      MODE_OFF:   led_d = 1'b0;
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = on_phase_s;
      MODE_BURST: led_d = on_phase_s && (bcnt_q < {1'b0, cur_q.burst});
      default:    led_d = 1'b0;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q     <= CFG_RST;
      shadow_q  <= CFG_RST;
      pending_q <= 1'b0;
      phase_q   <= {PER_W{1'b0}};
      bcnt_q    <= {BW{1'b0}};
      led_q     <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      phase_q   <= phase_d;
      bcnt_q    <= bcnt_d;
      led_q     <= led_d;
      pstart_q  <= pstart_d;
    end
  end

  assign led_o          = led_q;
  assign period_start_o = pstart_q;
  assign pending_o      = pending_q;

endmodule

// File: rtl/multi_blink.sv
// multi_blink: multi-channel LED pattern generator with a shared prescaler.
//   CLK, reset_n   - clock, asynchronous active-low reset
//   cfg_valid/cfg_ready - config handshake (accept on valid & ready)
//   cfg_chan       - target channel; values >= NUM_CH are dropped with cfg_err
//   cfg_mode, cfg_period, cfg_duty, cfg_burst - channel config fields
//   cfg_err        - one-cycle pulse after an out-of-range accept
//   led            - registered channel outputs
//   period_start   - per-channel one-cycle period wrap pulse
//   pending        - per-channel uncommitted config flag
module multi_blink
  import multi_blink_pkg::*;
#(
  parameter int CLK_HZ  = 16000000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_CH  = 2,
  parameter int PER_W   = 16,
  parameter int CNT_W   = 4
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_chan,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [PER_W-1:0]  cfg_duty,
  input  logic [CNT_W-1:0]  cfg_burst,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] period_start,
  output logic [NUM_CH-1:0] pending
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int DIV_W = calc_div_w(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("multi_blink: CLK_HZ/TICK_HZ must be at least 2");
  end
  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
    $error("multi_blink: NUM_CH must be in 1..16");
  end

  logic [DIV_W-1:0]  presc_q, presc_d;
  logic              tick_s;
  logic              cfg_err_q, cfg_err_d;
  logic              in_range_s;
  logic              accept_s;
  logic [15:0]       pend_pad_s;
  logic [NUM_CH-1:0] wr_s;
  logic [NUM_CH-1:0] led_s;
  logic [NUM_CH-1:0] pstart_s;
  logic [NUM_CH-1:0] pending_s;

  // Prescaler next count and tick decode.
  always_comb begin
    tick_s = (presc_q == DIV_W'(DIV - 1));
    if (tick_s) begin
      presc_d = {DIV_W{1'b0}};
    end else begin
      presc_d = presc_q + DIV_W'(1);
    end
  end

  // Channel decode and ready mux; depends on cfg_chan and pending only.
  always_comb begin
    in_range_s = ({1'b0, cfg_chan} < 5'(NUM_CH));
    pend_pad_s = 16'h0000;
    for (int i = 0; i < NUM_CH; i++) begin
      pend_pad_s[i] = pending_s[i];
    end
    if (in_range_s) begin
      cfg_ready = ~pend_pad_s[cfg_chan];
    end else begin
      cfg_ready = 1'b1;
    end
    accept_s  = cfg_valid && cfg_ready;
    cfg_err_d = accept_s && !in_range_s;
  end

  // Prescaler and error pulse registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= {DIV_W{1'b0}};
      cfg_err_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_s[i] = accept_s && in_range_s && (cfg_chan == 4'(i));

    blink_channel #(
      .PER_W (PER_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i          (CLK),
      .rst_ni         (reset_n),
      .tick_i         (tick_s),
      .wr_i           (wr_s[i]),
      .mode_i         (mode_e'(cfg_mode)),
      .period_i       (cfg_period),
      .duty_i         (cfg_duty),
      .burst_i        (cfg_burst),
      .led_o          (led_s[i]),
      .period_start_o (pstart_s[i]),
      .pending_o      (pending_s[i])
    );
  end

  assign cfg_err      = cfg_err_q;
  assign led          = led_s;
  assign period_start = pstart_s;
  assign pending      = pending_s;

endmodule

// File: tb/tb_multi_blink.sv
// tb_multi_blink: directed self-checking bench for multi_blink
// (CLK_HZ=16, TICK_HZ=4 -> DIV=4, NUM_CH=2). Cycle n is the n-th cycle
// after reset release; ticks fall on cycles with n % 4 == 3.
module tb_multi_blink;

  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_chan = 4'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_period = 16'd0;
  logic [15:0] cfg_duty = 16'd0;
  logic [3:0]  cfg_burst = 4'd0;
  logic        cfg_err;
  logic [1:0]  led;
  logic [1:0]  period_start;
  logic [1:0]  pending;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;

  multi_blink #(
    .CLK_HZ(16), .TICK_HZ(4), .NUM_CH(2), .PER_W(16), .CNT_W(4)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .cfg_burst(cfg_burst), .cfg_err(cfg_err),
    .led(led), .period_start(period_start), .pending(pending)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_until(input int n);
    if (cyc > n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_until cyc=%0d target=%0d", cyc, n);
    end
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan = 4'd0;
    repeat (3) @(posedge CLK);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drive_cfg(input logic [3:0] ch, input logic [1:0] md,
                           input logic [15:0] per, input logic [15:0] dty,
                           input logic [3:0] bst);
    cfg_valid = 1'b1; cfg_chan = ch; cfg_mode = md;
    cfg_period = per; cfg_duty = dty; cfg_burst = bst;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (led !== 2'b00) begin n_fail++; $display("FAIL reset_led got=%b exp=00", led); end
    n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL reset_pending got=%b exp=00", pending); end
    n_checks++; if (period_start !== 2'b00) begin n_fail++; $display("FAIL reset_pstart got=%b exp=00", period_start); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_blink();
    logic exp_led, exp_ps;
    do_reset();
    wait_until(8);
    drive_cfg(4'd0, 2'd2, 16'd4, 16'd1, 4'd0);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (pending !== 2'b01) begin n_fail++; $display("FAIL blink_pending_set got=%b exp=01", pending); end
    step();
    n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL blink_pending_clr got=%b exp=00", pending); end
    while (cyc < 60) begin
      step();
      exp_led = (cyc == 11) || (cyc == 12) || ((cyc >= 25) && (((cyc - 25) % 16) < 4));
      exp_ps  = (cyc >= 24) && (((cyc - 24) % 16) == 0);
      n_checks++; if (led !== {1'b0, exp_led}) begin n_fail++; $display("FAIL blink_led cyc=%0d got=%b exp=%b", cyc, led, {1'b0, exp_led}); end
      n_checks++; if (period_start !== {1'b0, exp_ps}) begin n_fail++; $display("FAIL blink_pstart cyc=%0d got=%b exp=%b", cyc, period_start, {1'b0, exp_ps}); end
    end
  endtask

  task automatic test_on_while_blink();
    do_reset();
    wait_until(8);
    drive_cfg(4'd0, 2'd2, 16'd4, 16'd1, 4'd0);
    step();
    cfg_valid = 1'b0;
    wait_until(26);
    drive_cfg(4'd0, 2'd1, 16'd4, 16'd1, 4'd0);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (pending !== 2'b01) begin n_fail++; $display("FAIL onblink_pending got=%b exp=01", pending); end
    step();
    drive_cfg(4'd0, 2'd1, 16'd0, 16'd0, 4'd0);
    #1;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL onblink_stall28 got=%b exp=0", cfg_ready); end
    step();
    cfg_chan = 4'd1;
    #1;
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL onblink_ch1_ready got=%b exp=1", cfg_ready); end
    step();
    n_checks++; if (pending !== 2'b11) begin n_fail++; $display("FAIL onblink_pending_both got=%b exp=11", pending); end
    cfg_chan = 4'd0;
    step();
    n_checks++; if (pending !== 2'b01) begin n_fail++; $display("FAIL onblink_ch1_commit got=%b exp=01", pending); end
    while (cyc < 40) begin
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL onblink_stall cyc=%0d got=%b exp=0", cyc, cfg_ready); end
      step();
    end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL onblink_ready40 got=%b exp=1", cfg_ready); end
    n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL onblink_pending40 got=%b exp=00", pending); end
    n_checks++; if (period_start !== 2'b01) begin n_fail++; $display("FAIL onblink_pstart40 got=%b exp=01", period_start); end
    n_checks++; if (led !== 2'b10) begin n_fail++; $display("FAIL onblink_led40 got=%b exp=10", led); end
    step();
    cfg_valid = 1'b0;
    n_checks++; if (pending !== 2'b01) begin n_fail++; $display("FAIL onblink_pending41 got=%b exp=01", pending); end
    n_checks++; if (led !== 2'b11) begin n_fail++; $display("FAIL onblink_led41 got=%b exp=11", led); end
    step();
    n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL onblink_pending42 got=%b exp=00", pending); end
    while (cyc < 60) begin
      step();
      n_checks++; if (led !== 2'b11) begin n_fail++; $display("FAIL onblink_led_on cyc=%0d got=%b exp=11", cyc, led); end
    end
  endtask

  task automatic test_burst();
    logic exp_led, exp_ps;
    do_reset();
    wait_until(8);
    drive_cfg(4'd1, 2'd3, 16'd2, 16'd1, 4'd3);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (pending !== 2'b10) begin n_fail++; $display("FAIL burst_pending got=%b exp=10", pending); end
    while (cyc < 104) begin
      step();
      if (cyc < 57) exp_led = (cyc == 11) || (cyc == 12) || ((cyc >= 17) && (cyc <= 20)) || ((cyc >= 25) && (cyc <= 28));
      else          exp_led = (((cyc - 57) % 48) < 24) && (((cyc - 57) % 8) < 4);
      exp_ps = (cyc >= 16) && (((cyc - 16) % 8) == 0);
      n_checks++; if (led !== {exp_led, 1'b0}) begin n_fail++; $display("FAIL burst_led cyc=%0d got=%b exp=%b", cyc, led, {exp_led, 1'b0}); end
      n_checks++; if (period_start !== {exp_ps, 1'b0}) begin n_fail++; $display("FAIL burst_pstart cyc=%0d got=%b exp=%b", cyc, period_start, {exp_ps, 1'b0}); end
    end
  endtask

  task automatic test_duty_edges();
    do_reset();
    wait_until(8);
    drive_cfg(4'd0, 2'd2, 16'd4, 16'd0, 4'd0);
    step();
    drive_cfg(4'd1, 2'd2, 16'd4, 16'd9, 4'd0);
    step();
    cfg_valid = 1'b0;
    wait_until(12);
    while (cyc < 60) begin
      n_checks++; if (led !== 2'b10) begin n_fail++; $display("FAIL duty_edge_led cyc=%0d got=%b exp=10", cyc, led); end
      step();
    end
  endtask

  task automatic test_period_zero();
    logic [1:0] exp_ps;
    do_reset();
    wait_until(8);
    drive_cfg(4'd0, 2'd2, 16'd0, 16'd1, 4'd0);
    step();
    drive_cfg(4'd1, 2'd2, 16'd1, 16'd1, 4'd0);
    step();
    cfg_valid = 1'b0;
    wait_until(12);
    while (cyc < 40) begin
      exp_ps = ((cyc % 4) == 0) ? 2'b11 : 2'b00;
      n_checks++; if (led !== 2'b11) begin n_fail++; $display("FAIL per0_led cyc=%0d got=%b exp=11", cyc, led); end
      n_checks++; if (period_start !== exp_ps) begin n_fail++; $display("FAIL per0_pstart cyc=%0d got=%b exp=%b", cyc, period_start, exp_ps); end
      step();
    end
  endtask

  task automatic test_cfg_err();
    do_reset();
    wait_until(5);
    drive_cfg(4'd5, 2'd1, 16'd4, 16'd1, 4'd1);
    #1;
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready got=%b exp=1", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
    n_checks++; if (pending !== 2'b00) begin n_fail++; $display("FAIL err_pending got=%b exp=00", pending); end
    step();
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got=%b exp=0", cfg_err); end
    drive_cfg(4'd2, 2'd1, 16'd4, 16'd1, 4'd1);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL err_ch2 got=%b exp=1", cfg_err); end
    repeat (4) begin
      step();
      n_checks++; if (led !== 2'b00 || pending !== 2'b00 || cfg_err !== 1'b0) begin
        n_fail++; $display("FAIL err_no_change cyc=%0d led=%b pending=%b err=%b exp=00/00/0", cyc, led, pending, cfg_err);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    wait_until(8);
    drive_cfg(4'd1, 2'd3, 16'd2, 16'd1, 4'd3);
    step();
    cfg_valid = 1'b0;
    wait_until(18);
    n_checks++; if (led !== 2'b10) begin n_fail++; $display("FAIL rst_mid_led_before got=%b exp=10", led); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (led !== 2'b00) begin n_fail++; $display("FAIL rst_mid_led_async got=%b exp=00", led); end
    n_checks++; if (pending !== 2'b00 || period_start !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_state pending=%b pstart=%b exp=00/00", pending, period_start);
    end
    repeat (2) @(posedge CLK);
    #1;
    reset_n = 1'b1;
    drive_cfg(4'd0, 2'd2, 16'd1, 16'd1, 4'd0);
    step();
    cfg_valid = 1'b0;
    n_checks++; if (pending !== 2'b01) begin n_fail++; $display("FAIL rst_mid_pending got=%b exp=01", pending); end
    while (cyc < 13) begin
      step();
      n_checks++; if (period_start !== ((cyc % 4 == 0) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL rst_mid_presc cyc=%0d got=%b exp=%b", cyc, period_start, (cyc % 4 == 0) ? 2'b01 : 2'b00);
      end
      n_checks++; if (led[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_led1 cyc=%0d got=%b exp=0", cyc, led[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_on_while_blink();
    test_burst();
    test_duty_edges();
    test_period_zero();
    test_cfg_err();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
